// File: rtl/cluster_frame_scheduler_pkg.sv
// Shared widths, frame layout and readout state encoding for the cluster frame scheduler.
package cluster_frame_scheduler_pkg;

    localparam int NCLUSTERS = 8;
    localparam int ADR_W     = 11;
    localparam int CNT_W     = 3;
    localparam int BXN_W     = 12;
    localparam int BXN_MAX   = 3563;
    localparam int FRAME_W   = NCLUSTERS * (ADR_W + CNT_W) + NCLUSTERS + BXN_W;

    // Packed so that adr[k]/cnt[k] line up with the encoder's flat slot buses.
    typedef struct packed {
        logic [BXN_W-1:0]                  bxn;
        logic [NCLUSTERS-1:0]              mask;
        logic [NCLUSTERS-1:0][CNT_W-1:0]   cnt;
        logic [NCLUSTERS-1:0][ADR_W-1:0]   adr;
    } frame_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } rd_state_e;

endpackage

// File: rtl/cluster_frame_scheduler_if.sv
// Encoder-side inputs and the serialized cluster stream (valid/ready) of the scheduler.
interface cluster_frame_scheduler_if;
    import cluster_frame_scheduler_pkg::*;

    logic                         bx0;
    logic                         enable;
    logic [NCLUSTERS*ADR_W-1:0]   adr_in;
    logic [NCLUSTERS*CNT_W-1:0]   cnt_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [ADR_W-1:0]             out_adr;
    logic [CNT_W-1:0]             out_cnt;
    logic [BXN_W-1:0]             out_bxn;
    logic                         out_last;

    modport master (
        input  bx0, enable, adr_in, cnt_in, out_ready,
        output out_valid, out_adr, out_cnt, out_bxn, out_last
    );

    modport slave (
        output bx0, enable, adr_in, cnt_in, out_ready,
        input  out_valid, out_adr, out_cnt, out_bxn, out_last
    );

endinterface

// File: rtl/cluster_frame_scheduler_frame_fifo.sv
// Synchronous frame FIFO; write visible one cycle after push, dout is the head combinationally.
// Push on full is ignored unless a pop happens in the same cycle.
module frame_fifo #(
    parameter int WIDTH = 132,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd  = pop && !empty;
    assign w_wr  = push && (!full || w_rd);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cluster_frame_scheduler.sv
// BX-phased capture of the 8-slot encoder frame, buffered and serialized one valid cluster per beat.
// Capture-to-first-beat 2 cycles; stalls hold the output, a full FIFO drops whole frames.
module cluster_frame_scheduler #(
    parameter int FIFO_DEPTH    = 4,
    parameter int CAPTURE_PHASE = 4,
    parameter int NUM_STRIPS    = 1536,
    parameter int BXN_MAX       = cluster_frame_scheduler_pkg::BXN_MAX
) (
    input  logic                         clock4x,
    input  logic                         global_reset_n,
    cluster_frame_scheduler_if.master    bus,
    output logic [2:0]                   phase,
    output logic [15:0]                  overflow_cnt,
    output logic                         bx0_misaligned
);
    import cluster_frame_scheduler_pkg::*;

    logic [2:0]           r_phase;
    logic [BXN_W-1:0]     r_bxn;
    logic                 r_misaligned;
    logic [15:0]          r_ovf;
    logic                 r_cap_vld;
    frame_t               r_cap_frame;
    frame_t               w_cap_frame;
    logic                 w_capture;

    rd_state_e            r_state, w_state_nxt;
    logic [NCLUSTERS-1:0] r_rem, w_rem_nxt, w_cur_mask;
    logic [2:0]           w_slot;
    logic                 w_last, w_beat, w_pop, w_push, w_drop, w_full, w_empty;
    logic [FRAME_W-1:0]   w_fifo_dout;
    frame_t               w_head;

    assign phase          = r_phase;
    assign overflow_cnt   = r_ovf;
    assign bx0_misaligned = r_misaligned;

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_phase      <= '0;
            r_bxn        <= '0;
            r_misaligned <= 1'b0;
        end else if (bus.bx0) begin
            r_phase <= '0;
            r_bxn   <= '0;
            if (r_phase != 3'd7) r_misaligned <= 1'b1;
        end else begin
            r_phase <= r_phase + 3'd1;
            if (r_phase == 3'd7) r_bxn <= (r_bxn == BXN_W'(BXN_MAX)) ? '0 : r_bxn + 1'b1;
        end
    end

    assign w_capture = (r_phase == 3'(CAPTURE_PHASE)) && bus.enable;

    always_comb begin
        w_cap_frame     = '0;
        w_cap_frame.adr = bus.adr_in;
        w_cap_frame.cnt = bus.cnt_in;
        w_cap_frame.bxn = r_bxn;
        for (int k = 0; k < NCLUSTERS; k++)
            w_cap_frame.mask[k] = int'(w_cap_frame.adr[k]) < NUM_STRIPS;
    end

    // Frames with no valid slot never reach the FIFO, so they cannot count as drops either.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_cap_vld   <= 1'b0;
            r_cap_frame <= '0;
            r_ovf       <= '0;
        end else begin
            r_cap_vld <= w_capture && (|w_cap_frame.mask);
            if (w_capture) r_cap_frame <= w_cap_frame;
            if (w_drop && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
        end
    end

    assign w_push = r_cap_vld && (!w_full || w_pop);
    assign w_drop = r_cap_vld && w_full && !w_pop;

    frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_frame_fifo (
        .clk   (clock4x),
        .rst_n (global_reset_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_cap_frame),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_head = frame_t'(w_fifo_dout);

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // In IDLE the walk starts from the head frame's mask; EMIT continues from what is left.
    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_cur_mask    = (r_state == ST_EMIT) ? r_rem : w_head.mask;
        w_slot        = '0;
        for (int k = NCLUSTERS - 1; k >= 0; k--)
            if (w_cur_mask[k]) w_slot = 3'(k);
        w_last        = (w_cur_mask & ~(NCLUSTERS'(1) << w_slot)) == '0;
        w_beat        = !w_empty && bus.out_ready;
        w_pop         = w_beat && w_last;
        bus.out_valid = !w_empty;
        bus.out_adr   = '0;
        bus.out_cnt   = '0;
        bus.out_bxn   = '0;
        bus.out_last  = 1'b0;
        if (!w_empty) begin
            bus.out_adr  = w_head.adr[w_slot];
            bus.out_cnt  = w_head.cnt[w_slot];
            bus.out_bxn  = w_head.bxn;
            bus.out_last = w_last;
        end
        if (w_beat) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_EMIT;
                w_rem_nxt   = w_cur_mask & ~(NCLUSTERS'(1) << w_slot);
            end
        end
    end

endmodule

// File: doc/cluster_frame_scheduler.md
Name: cluster_frame_scheduler

Overview:
Controls readout of the 8-cluster-per-BX encoder output (8×{adr[10:0], cnt[2:0]} refreshed once per 8 clock4x cycles). Owns the 8-phase BX schedule aligned to bx0 and captures the encoder's cluster frame on a fixed phase. Tags each frame with a bunch-crossing number and buffers it in a small frame FIFO. Serializes only the valid clusters onto a single valid/ready stream for the downstream link formatter.

Parameters:
FIFO_DEPTH, 4, frame FIFO depth in frames; power of two, ≥2
CAPTURE_PHASE, 4, phase value on which encoder outputs are sampled
NUM_STRIPS, 1536, cluster valid iff adr < NUM_STRIPS
BXN_MAX, 3563, last bunch-crossing number before wrap

Ports:
clock4x  in  1  160 MHz clock
global_reset_n  in  1  reset; one clock; reset is asynchronous and active-low
bx0  in  1  BX0 pulse, synchronous to clock4x, one cycle wide
enable  in  1  1 = capture frames; 0 = no new captures, FIFO keeps draining
adr_in  in  88  slot k address at [11k+10:11k], k=0..7
cnt_in  in  24  slot k count at [3k+2:3k]
phase  out  3  current schedule phase
out_valid  out  1  cluster available
out_ready  in  1  downstream accepts
out_adr  out  11  cluster address
out_cnt  out  3  cluster count
out_bxn  out  12  BX number of the cluster's frame
out_last  out  1  last valid cluster of its frame
overflow_cnt  out  16  frames dropped on full FIFO, saturating
bx0_misaligned  out  1  sticky: bx0 seen while phase != 7

Behaviour:
- Reset (async): phase=0, bxn=0, FIFO empty, out_valid=0, out_last=0, out_adr/out_cnt/out_bxn=0, overflow_cnt=0, bx0_misaligned=0. Reset mid-stream discards all buffered frames; no partial frame survives.
- Phase: increments mod 8 every cycle. bx0=1 in cycle t -> phase=0 and bxn=0 in t+1. If bx0=1 while phase!=7, set bx0_misaligned (cleared only by reset).
- bxn: increments on 7->0 wrap without bx0; BXN_MAX wraps to 0. bx0 overrides the increment.
- Capture: cycle with phase==CAPTURE_PHASE and enable=1. Sample adr_in/cnt_in/bxn and compute an 8-bit valid mask (adr_k < NUM_STRIPS).
- Mask==0: frame is discarded, with no FIFO push and no overflow count.
- Mask!=0 and FIFO not full: push {clusters, mask, bxn} in the cycle after capture.
- FIFO full at push: frame dropped; overflow_cnt += 1, saturating at 16'hFFFF.
- Push and pop in the same cycle on a full FIFO: pop has priority, so the push succeeds.
- Readout: head frame emitted in ascending slot order, skipping slots with mask bit 0, one cluster per accepted beat.
- out_last=1 on the highest-index valid slot. The frame is popped on that beat's handshake, and the next frame's first cluster may present in the following cycle (no bubble required, at most one allowed).
- Handshake: transfer when out_valid & out_ready. While out_valid & !out_ready, all out_* stay stable. out_valid never drops without a transfer except on reset.
- Latency: with FIFO empty and output idle, capture at cycle C -> out_valid=1 at C+2 with slot = lowest valid index.
- Throughput: a full frame of 8 valid clusters takes 8 beats, i.e. one BX period at full ready. Sustained dense traffic with stalls fills the FIFO and drops frames.
- enable deassert: captures stop immediately; frames already buffered drain normally.

Decomposition:
- Shared package/include cluster_pkg:
  - NCLUSTERS=8, ADR_W=11, CNT_W=3, BXN_W=12, BXN_MAX
  - Frame word width = 8*(ADR_W+CNT_W)+8+BXN_W = 132
  - Slot field-offset macros
- Sub-module frame_fifo: synchronous FIFO, parameterized width/depth.
  - Ports: push, pop, din, dout, full, empty.
  - Same async active-low reset.
- Top holds:
  - phase/bxn logic
  - capture and valid-mask logic
  - drop/overflow counter
  - slot-walk readout FSM (IDLE, EMIT; slot index register plus remaining-mask register)

Test Plan:
- Reset-then-bx0: release reset, pulse bx0 at t -> phase=0 at t+1, phase=7 at t+8; bxn 0->1 at t+9; bx0_misaligned stays 0.
- Sparse frame: slots 1 and 5 valid (adr 10 cnt 3, adr 1535 cnt 7), others adr 11'h7FF; out_ready=1 -> out_valid at C+2 with adr 10. Next beat: adr 1535, out_last=1, out_bxn=capture bxn.
- Empty frame: all adr ≥1536 -> out_valid stays 0, no FIFO push, overflow_cnt=0.
- Backpressure/overflow: out_ready=0, 6 consecutive BXs of full frames with FIFO_DEPTH=4 -> overflow_cnt=2 and first cluster held stable. Release ready -> exactly 32 beats, 4 out_last pulses, bxn values consecutive.
- Misaligned bx0: bx0 at phase 3 -> phase=0 next cycle, bxn=0, bx0_misaligned=1 persisting until reset.
- Reset mid-readout: assert global_reset_n=0 during beat 3 of a frame -> out_valid=0 immediately (async). After release, no stale clusters are emitted.
